// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/flush/freeze/halt control for the five-stage pipe
// HAZARD_FWD_EN: forwarding present, only load-use hazards stall.
module pipe_hazard_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_vld,
  input  logic        id_rt_vld,
  input  logic        ex_RegWriteEN,
  input  logic        ex_MemEn,
  input  logic        ex_MemWr,
  input  logic [2:0]  ex_dst_reg_num,
  input  logic        mem_RegWriteEN,
  input  logic [2:0]  mem_dst_reg_num,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  input  logic        halt_in,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t     state_q, state_d, run_next;
  logic [8:0] freeze_cnt_q, freeze_cnt_d;
  logic [9:0] busy_len;
  logic       timeout_set;
  logic       ex_match, data_hazard;
  logic [4:0] run_en, en;
  logic       run_ifid_flush, run_idex_flush;

  assign ex_match = (id_rs_vld & (id_rs == ex_dst_reg_num)) |
                    (id_rt_vld & (id_rt == ex_dst_reg_num));

`ifdef HAZARD_FWD_EN
  logic unused_mem_fields;
  assign unused_mem_fields = &{1'b0, mem_RegWriteEN, mem_dst_reg_num};
  assign data_hazard = ex_MemEn & ~ex_MemWr & ex_RegWriteEN & ex_match;
`else
  logic mem_match;
  logic unused_ex_mem_ctl;
  assign unused_ex_mem_ctl = &{1'b0, ex_MemEn, ex_MemWr};
  assign mem_match = (id_rs_vld & (id_rs == mem_dst_reg_num)) |
                     (id_rt_vld & (id_rt == mem_dst_reg_num));
  assign data_hazard = (ex_RegWriteEN & ex_match) | (mem_RegWriteEN & mem_match);
`endif

  // Priority response used in RUN and on the cycle a freeze releases
  always_comb begin
    run_en         = 5'b11111;
    run_ifid_flush = 1'b0;
    run_idex_flush = 1'b0;
    run_next       = RUN;
    if (halt_in) begin
      run_en   = 5'b00000;
      run_next = HALT;
    end else if (mem_busy) begin
      run_en   = 5'b00000;
      run_next = FREEZE;
    end else if (ex_redirect) begin
      run_ifid_flush = 1'b1;
      run_idex_flush = 1'b1;
    end else if (data_hazard) begin
      run_en         = 5'b00111;
      run_idex_flush = 1'b1;
    end
  end

  // The RUN cycle that saw mem_busy first is busy cycle 1, so add it plus this cycle
  assign busy_len = {1'b0, freeze_cnt_q} + 10'd2;

  always_comb begin
    state_d      = state_q;
    freeze_cnt_d = 9'd0;
    timeout_set  = 1'b0;
    en           = 5'b00000;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    case (state_q)
      RUN: begin
        en         = run_en;
        ifid_flush = run_ifid_flush;
        idex_flush = run_idex_flush;
        state_d    = run_next;
      end
      FREEZE: begin
        if (mem_busy && !halt_in) begin
          freeze_cnt_d = freeze_cnt_q + 9'd1;
          if (busy_len >= 10'(TIMEOUT)) begin
            timeout_set  = 1'b1;
            freeze_cnt_d = 9'd0;
            state_d      = HALT;
          end
        end else begin
          en         = run_en;
          ifid_flush = run_ifid_flush;
          idex_flush = run_idex_flush;
          state_d    = run_next;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
    if (!rst) begin
      en         = 5'b00000;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  assign pc_en    = en[4];
  assign ifid_en  = en[3];
  assign idex_en  = en[2];
  assign exmem_en = en[1];
  assign memwb_en = en[0];
  assign halted   = (state_q == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      freeze_cnt_q <= 9'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state_q      <= state_d;
      freeze_cnt_q <= freeze_cnt_d;
      if (timeout_set)
        mem_timeout <= 1'b1;
      if (!en[4] && state_q != HALT && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Pipeline control block for the five-stage core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers, reads the control fields those registers present on their outputs, and drives back their `en` and flush inputs. It resolves data hazards with stalls and bubbles, flushes younger instructions on taken branches and jumps, and freezes the whole pipe during multi-cycle memory accesses. It holds the halted state after `dump`, and keeps a memory-timeout watchdog and a stall-cycle counter.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum consecutive `mem_busy` cycles before `mem_timeout` fires.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  3 each  source register numbers of the instruction in decode.
- `id_rs_vld`, `id_rt_vld`  in  1 each  the decode instruction actually reads that source.
- `ex_RegWriteEN`, `ex_MemEn`, `ex_MemWr`  in  1 each  ID/EX control outputs.
- `ex_dst_reg_num`  in  3  ID/EX destination register.
- `mem_RegWriteEN`  in  1  EX/MEM write enable.
- `mem_dst_reg_num`  in  3  EX/MEM destination register.
- `ex_redirect`  in  1  EX resolved a taken branch or jump this cycle.
- `mem_busy`  in  1  data memory has not completed its access.
- `halt_in`  in  1  a `dump` instruction is in WB.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  pipeline register enables.
- `ifid_flush`, `idex_flush`  out  1 each  load a NOP/bubble (all controls 0) on the next edge.
- `halted`  out  1  core is stopped.
- `mem_timeout`  out  1  sticky; the watchdog fired.
- `stall_cycles`  out  16  saturating count of cycles with `pc_en`=0 outside HALT.

## Operation
- The state machine has three states: RUN, FREEZE and HALT. Reset enters RUN.
- Outputs are combinational from state and inputs. The response in RUN is decided by the highest-priority condition present:
  - `halt_in`: all enables 0, no flush; next state HALT.
  - `mem_busy`: all five enables 0, no flush; next state FREEZE. `ex_redirect` is ignored here because EX is frozen and re-asserts it later.
  - `ex_redirect`: all enables 1, `ifid_flush`=1, `idex_flush`=1.
  - data hazard: `pc_en`=0, `ifid_en`=0, `idex_en`=1 with `idex_flush`=1 (bubble), `exmem_en`=`memwb_en`=1.
  - otherwise: all enables 1, no flush.
- A data hazard is a match: (`id_rs_vld` & `id_rs`==dst) | (`id_rt_vld` & `id_rt`==dst).
- In FREEZE:
  - All enables are 0 while `mem_busy`=1.
  - When `mem_busy`=0, outputs follow the RUN priority list in the same cycle and the next state is RUN.
  - A 9-bit counter increments each FREEZE cycle. At `TIMEOUT` consecutive busy cycles, `mem_timeout` is set and the next state is HALT.
- In HALT: all enables 0, flushes 0, `halted`=1. HALT is left only by reset.
- `stall_cycles` increments when `pc_en`=0, the state is not HALT and `rst` is high. It saturates at 0xFFFF.

## Timing
- Reset values:
  - state RUN, `halted`=0, `mem_timeout`=0, `stall_cycles`=0, freeze counter 0.
  - While `rst`=0, all enables and flushes are driven 0.
- Latency is zero: a hazard seen in cycle N gates the edge ending cycle N.
- A load-use hazard costs exactly 1 bubble. In the next cycle the load is in EX/MEM and no longer matches.
- `ex_redirect` coinciding with a data hazard: the flush wins and there is no stall.
- `halt_in` in the same cycle as `mem_busy`: HALT wins.
- Reset asserted mid-FREEZE aborts immediately, clears the counter, and returns to RUN.

## Configuration
- `HAZARD_FWD_EN` defined (forwarding present): the data hazard is a load-use only, i.e. `ex_MemEn` & ~`ex_MemWr` & `ex_RegWriteEN` & match against `ex_dst_reg_num`.
- Undefined (no forwarding): the data hazard is (`ex_RegWriteEN` & match `ex_dst_reg_num`) | (`mem_RegWriteEN` & match `mem_dst_reg_num`). A dependent instruction stalls up to 2 cycles.

## Test plan
- Load-use (`HAZARD_FWD_EN`):
  - Stimulus: `ex_MemEn`=1, `ex_MemWr`=0, `ex_RegWriteEN`=1, `ex_dst_reg_num`=3, `id_rs`=3, `id_rs_vld`=1.
  - Required: one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `stall_cycles` becomes 1.
- No forwarding (macro undefined):
  - Stimulus: an ALU write to R5 followed by a dependent read of R5.
  - Required: 2 bubble cycles, then all enables 1.
- Redirect plus hazard:
  - Stimulus: `ex_redirect`=1 together with a load-use match.
  - Required: `ifid_flush`=`idex_flush`=1, `pc_en`=1, `stall_cycles` unchanged.
- Memory freeze:
  - Stimulus: `mem_busy` high for 4 cycles, then `mem_busy`=0.
  - Required: all enables 0 for 4 cycles, back to RUN, `stall_cycles`=4.
- Timeout and halt:
  - Stimulus 1: `mem_busy` held 255 cycles. Required: `mem_timeout`=1, `halted`=1.
  - Stimulus 2: `halt_in` pulse. Required: `halted`=1 stays set until `rst` is pulsed low mid-run, then all outputs return to their reset values.
